// File: rtl/frl_alloc_ctrl.sv
// Free register list sequencer: compacted all-or-nothing rename grants, merged
// commit/squash free buffering with FRL drain, and flush/drain allocation blocking.
module frl_alloc_ctrl #(
  parameter int NUM_PHYS_REGS = 128,
  parameter int ALLOC_W       = 4,
  parameter int FREE_W        = 4,
  parameter int COMMIT_W      = 4,
  parameter int FBUF_DEPTH    = 16,
  localparam int PREG_W       = $clog2(NUM_PHYS_REGS),
  localparam int CNT_W        = $clog2(FBUF_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC_W-1:0]           alloc_req_valid_in,
  output logic                         alloc_grant_out,
  output logic [ALLOC_W*PREG_W-1:0]    alloc_pregs_out,
  input  logic                         frl_valid_in,
  input  logic [ALLOC_W*PREG_W-1:0]    frl_regs_in,
  output logic [ALLOC_W-1:0]           frl_acquire_ready_out,
  output logic [FREE_W-1:0]            frl_free_valid_out,
  output logic [FREE_W*PREG_W-1:0]     frl_free_regs_out,
  input  logic [COMMIT_W-1:0]          commit_free_valid_in,
  input  logic [COMMIT_W*PREG_W-1:0]   commit_free_regs_in,
  output logic                         commit_free_ready_out,
  input  logic [COMMIT_W-1:0]          squash_free_valid_in,
  input  logic [COMMIT_W*PREG_W-1:0]   squash_free_regs_in,
  output logic                         squash_free_ready_out,
  input  logic                         flush_in,
  input  logic                         flush_done_in,
  output logic [CNT_W-1:0]             fbuf_count_out,
  output logic [1:0]                   state_out,
  output logic                         proto_err_out
);

  localparam int PTR_W  = $clog2(FBUF_DEPTH);
  localparam int NSLOT  = 2 * COMMIT_W;
  localparam int SLOT_W = $clog2(NSLOT) + 1;
  localparam int AW     = $clog2(ALLOC_W) + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next, deq_cnt;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic              proto_err_reg, proto_err_next;
  logic [PREG_W-1:0] fbuf_mem [FBUF_DEPTH];
  logic [PREG_W-1:0] frl_regs [ALLOC_W];
  logic [PREG_W-1:0] in_regs  [NSLOT];
  logic [PREG_W-1:0] enq_data [NSLOT];
  logic [NSLOT-1:0]  in_valid;
  logic [SLOT_W-1:0] enq_cnt;
  logic [AW-1:0]     req_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_frl_unpack
      assign frl_regs[gi] = frl_regs_in[gi*PREG_W +: PREG_W];
    end
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_src_unpack
      assign in_regs[gi]          = commit_free_regs_in[gi*PREG_W +: PREG_W];
      assign in_regs[COMMIT_W+gi] = squash_free_regs_in[gi*PREG_W +: PREG_W];
    end
    for (gi = 0; gi < FREE_W; gi++) begin : g_free_port
      assign frl_free_valid_out[gi]               = count_reg > CNT_W'(gi);
      assign frl_free_regs_out[gi*PREG_W +: PREG_W] = fbuf_mem[rd_ptr_reg + PTR_W'(gi)];
    end
  endgenerate

  assign alloc_grant_out = (state_reg == ST_RUN) && !flush_in && frl_valid_in;

  // Lane i takes the FRL entry whose index equals the number of requesting lanes below it.
  always_comb begin
    alloc_pregs_out       = '0;
    frl_acquire_ready_out = '0;
    req_cnt               = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_req_valid_in[i]) begin
        for (int s = 0; s < ALLOC_W; s++) begin
          if (alloc_grant_out && req_cnt == AW'(s)) begin
            alloc_pregs_out[i*PREG_W +: PREG_W] = frl_regs[s];
            frl_acquire_ready_out[s]            = 1'b1;
          end
        end
        req_cnt = req_cnt + AW'(1);
      end
    end
  end

  // Readies look only at registered occupancy, so a full-width enqueue always fits.
  assign commit_free_ready_out = count_reg <= CNT_W'(FBUF_DEPTH - COMMIT_W);
  assign squash_free_ready_out = count_reg <= CNT_W'(FBUF_DEPTH - NSLOT);
  assign in_valid = {squash_free_valid_in & {COMMIT_W{squash_free_ready_out}},
                     commit_free_valid_in & {COMMIT_W{commit_free_ready_out}}};

  always_comb begin
    enq_cnt = '0;
    for (int s = 0; s < NSLOT; s++) enq_data[s] = '0;
    for (int j = 0; j < NSLOT; j++) begin
      if (in_valid[j]) begin
        for (int s = 0; s < NSLOT; s++) begin
          if (enq_cnt == SLOT_W'(s)) enq_data[s] = in_regs[j];
        end
        enq_cnt = enq_cnt + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    deq_cnt    = (count_reg >= CNT_W'(FREE_W)) ? CNT_W'(FREE_W) : count_reg;
    count_next = count_reg + CNT_W'(enq_cnt) - deq_cnt;
    proto_err_next = proto_err_reg
                   | (|commit_free_valid_in && !commit_free_ready_out)
                   | (|squash_free_valid_in && !squash_free_ready_out)
                   | (flush_done_in && state_reg != ST_FLUSH);
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (flush_in) state_next = ST_FLUSH;
      ST_FLUSH: if (flush_done_in) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (flush_in)
          state_next = ST_FLUSH;
        else if (count_reg == '0 && !(|commit_free_valid_in) && !(|squash_free_valid_in))
          state_next = ST_RUN;
      end
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      rd_ptr_reg    <= rd_ptr_reg + PTR_W'(deq_cnt);
      wr_ptr_reg    <= wr_ptr_reg + PTR_W'(enq_cnt);
      proto_err_reg <= proto_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (SLOT_W'(s) < enq_cnt) fbuf_mem[wr_ptr_reg + PTR_W'(s)] <= enq_data[s];
      end
    end
  end

  assign fbuf_count_out = count_reg;
  assign state_out      = state_reg;
  assign proto_err_out  = proto_err_reg;

endmodule

// File: tb/tb_frl_alloc_ctrl.sv
// Scoreboard bench for frl_alloc_ctrl: stimulus queues expected grants and frees,
// a negedge monitor pops them whenever the DUT presents a grant or a free.
module tb_frl_alloc_ctrl;
  localparam int PW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alloc_req_valid_in;
  logic        alloc_grant_out;
  logic [27:0] alloc_pregs_out;
  logic        frl_valid_in;
  logic [27:0] frl_regs_in;
  logic [3:0]  frl_acquire_ready_out;
  logic [3:0]  frl_free_valid_out;
  logic [27:0] frl_free_regs_out;
  logic [3:0]  commit_free_valid_in;
  logic [27:0] commit_free_regs_in;
  logic        commit_free_ready_out;
  logic [3:0]  squash_free_valid_in;
  logic [27:0] squash_free_regs_in;
  logic        squash_free_ready_out;
  logic        flush_in;
  logic        flush_done_in;
  logic [4:0]  fbuf_count_out;
  logic [1:0]  state_out;
  logic        proto_err_out;

  frl_alloc_ctrl dut (
    .clk(clk), .rst(rst),
    .alloc_req_valid_in(alloc_req_valid_in), .alloc_grant_out(alloc_grant_out),
    .alloc_pregs_out(alloc_pregs_out), .frl_valid_in(frl_valid_in),
    .frl_regs_in(frl_regs_in), .frl_acquire_ready_out(frl_acquire_ready_out),
    .frl_free_valid_out(frl_free_valid_out), .frl_free_regs_out(frl_free_regs_out),
    .commit_free_valid_in(commit_free_valid_in), .commit_free_regs_in(commit_free_regs_in),
    .commit_free_ready_out(commit_free_ready_out),
    .squash_free_valid_in(squash_free_valid_in), .squash_free_regs_in(squash_free_regs_in),
    .squash_free_ready_out(squash_free_ready_out),
    .flush_in(flush_in), .flush_done_in(flush_done_in),
    .fbuf_count_out(fbuf_count_out), .state_out(state_out), .proto_err_out(proto_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] pregs;
    logic [3:0]  ready;
  } alloc_exp_t;

  alloc_exp_t    aq[$];
  logic [PW-1:0] fq[$];
  alloc_exp_t    a_exp;
  logic [PW-1:0] f_exp;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {PW'(l3), PW'(l2), PW'(l1), PW'(l0)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_alloc(input logic [27:0] pregs, input logic [3:0] ready);
    alloc_exp_t e;
    e.pregs = pregs;
    e.ready = ready;
    aq.push_back(e);
    $display("issue alloc: pregs=%h ready=%b", pregs, ready);
  endtask

  // Monitor: one line per observed grant or drained free.
  always @(negedge clk) begin
    if (alloc_grant_out === 1'b1) begin
      if (aq.size() == 0) begin
        total++; bad++;
        $display("FAIL alloc_unexpected: got grant pregs=%h expected no grant", alloc_pregs_out);
      end else begin
        a_exp = aq.pop_front();
        $display("grant: pregs=%h ready=%b", alloc_pregs_out, frl_acquire_ready_out);
        chk("alloc_pregs", 64'(alloc_pregs_out), 64'(a_exp.pregs));
        chk("alloc_ready", 64'(frl_acquire_ready_out), 64'(a_exp.ready));
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (frl_free_valid_out[j] === 1'b1) begin
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL free_unexpected: got port%0d reg %0d expected none", j,
                   frl_free_regs_out[j*PW +: PW]);
        end else begin
          f_exp = fq.pop_front();
          $display("free: port%0d reg=%0d", j, frl_free_regs_out[j*PW +: PW]);
          chk("free_reg", 64'(frl_free_regs_out[j*PW +: PW]), 64'(f_exp));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alloc_req_valid_in = '0; frl_valid_in = 1'b0; frl_regs_in = '0;
    commit_free_valid_in = '0; commit_free_regs_in = '0;
    squash_free_valid_in = '0; squash_free_regs_in = '0;
    flush_in = 1'b0; flush_done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", 64'(state_out), 64'd0);
    chk("reset_count", 64'(fbuf_count_out), 64'd0);
    chk("reset_proto_err", 64'(proto_err_out), 64'd0);
    chk("reset_free_valid", 64'(frl_free_valid_out), 64'd0);
    chk("reset_commit_ready", 64'(commit_free_ready_out), 64'd1);
    chk("reset_squash_ready", 64'(squash_free_ready_out), 64'd1);

    // Full-width request
    alloc_req_valid_in = 4'b1111; frl_valid_in = 1'b1; frl_regs_in = pack4(10, 11, 12, 13);
    push_alloc(pack4(10, 11, 12, 13), 4'b1111);
    cyc();

    // Sparse request held while FRL not valid, then granted
    alloc_req_valid_in = 4'b0101; frl_valid_in = 1'b0; frl_regs_in = pack4(20, 21, 22, 23);
    #1;
    chk("novalid_grant", 64'(alloc_grant_out), 64'd0);
    chk("novalid_pregs", 64'(alloc_pregs_out), 64'd0);
    chk("novalid_ready", 64'(frl_acquire_ready_out), 64'd0);
    cyc();
    frl_valid_in = 1'b1;
    push_alloc(pack4(20, 0, 21, 0), 4'b0011);
    cyc();

    // req=1010 compaction example
    alloc_req_valid_in = 4'b1010; frl_regs_in = pack4(30, 31, 32, 33);
    push_alloc(pack4(0, 30, 0, 31), 4'b0011);
    cyc();

    // Grant with no requests
    alloc_req_valid_in = 4'b0000;
    push_alloc(28'd0, 4'b0000);
    cyc();
    frl_valid_in = 1'b0;

    // Sparse commit + squash merge in one cycle
    commit_free_valid_in = 4'b1001; commit_free_regs_in = pack4(5, 0, 0, 7);
    squash_free_valid_in = 4'b0010; squash_free_regs_in = pack4(0, 9, 0, 0);
    fq.push_back(7'd5); fq.push_back(7'd7); fq.push_back(7'd9);
    $display("issue frees: 5 7 9");
    cyc();
    commit_free_valid_in = '0; squash_free_valid_in = '0;
    chk("merge_count", 64'(fbuf_count_out), 64'd3);
    chk("merge_free_valid", 64'(frl_free_valid_out), 64'b0111);
    cyc();
    chk("merge_count_after", 64'(fbuf_count_out), 64'd0);

    // Fill: full commit + squash each cycle; third squash arrives while not ready
    for (int c = 0; c < 3; c++) begin
      commit_free_valid_in = 4'b1111;
      commit_free_regs_in  = pack4(40 + 8*c, 41 + 8*c, 42 + 8*c, 43 + 8*c);
      squash_free_valid_in = 4'b1111;
      squash_free_regs_in  = pack4(44 + 8*c, 45 + 8*c, 46 + 8*c, 47 + 8*c);
      for (int k = 0; k < 4; k++) fq.push_back(PW'(40 + 8*c + k));
      if (c < 2) for (int k = 0; k < 4; k++) fq.push_back(PW'(44 + 8*c + k));
      $display("issue fill cycle %0d", c);
      cyc();
      if (c == 0) begin
        chk("fill_count0", 64'(fbuf_count_out), 64'd8);
        chk("fill_squash_ready8", 64'(squash_free_ready_out), 64'd1);
      end else begin
        chk("fill_count", 64'(fbuf_count_out), 64'd12);
        chk("fill_squash_ready12", 64'(squash_free_ready_out), 64'd0);
        chk("fill_commit_ready12", 64'(commit_free_ready_out), 64'd1);
      end
    end
    commit_free_valid_in = '0; squash_free_valid_in = '0;
    chk("proto_err_set", 64'(proto_err_out), 64'd1);
    repeat (4) cyc();
    chk("fill_drained", 64'(fbuf_count_out), 64'd0);
    chk("proto_err_sticky", 64'(proto_err_out), 64'd1);

    // Flush with request pending
    alloc_req_valid_in = 4'b1111; frl_valid_in = 1'b1; frl_regs_in = pack4(50, 51, 52, 53);
    flush_in = 1'b1;
    #1;
    chk("flush_grant", 64'(alloc_grant_out), 64'd0);
    chk("flush_ready", 64'(frl_acquire_ready_out), 64'd0);
    cyc();
    flush_in = 1'b0;
    chk("flush_state", 64'(state_out), 64'd1);
    for (int c = 0; c < 3; c++) begin
      squash_free_valid_in = 4'b1111;
      squash_free_regs_in  = pack4(80 + 4*c, 81 + 4*c, 82 + 4*c, 83 + 4*c);
      for (int k = 0; k < 4; k++) fq.push_back(PW'(80 + 4*c + k));
      $display("issue squash cycle %0d", c);
      cyc();
      chk("flush_hold_grant", 64'(alloc_grant_out), 64'd0);
    end
    squash_free_valid_in = '0;
    flush_done_in = 1'b1;
    cyc();
    flush_done_in = 1'b0;
    chk("drain_state", 64'(state_out), 64'd2);
    chk("drain_grant", 64'(alloc_grant_out), 64'd0);
    cyc();
    chk("drain_exit_state", 64'(state_out), 64'd0);
    push_alloc(pack4(50, 51, 52, 53), 4'b1111);
    cyc();
    alloc_req_valid_in = '0; frl_valid_in = 1'b0;

    // Reset in DRAIN with six buffered frees
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0; flush_done_in = 1'b1;
    cyc();
    flush_done_in = 1'b0;
    commit_free_valid_in = 4'b1111; commit_free_regs_in = pack4(100, 101, 102, 103);
    squash_free_valid_in = 4'b0011; squash_free_regs_in = pack4(104, 105, 0, 0);
    for (int k = 0; k < 4; k++) fq.push_back(PW'(100 + k));
    $display("issue frees before reset: 100..105");
    cyc();
    commit_free_valid_in = '0; squash_free_valid_in = '0;
    chk("prerst_state", 64'(state_out), 64'd2);
    chk("prerst_count", 64'(fbuf_count_out), 64'd6);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_count", 64'(fbuf_count_out), 64'd0);
    chk("rst_state", 64'(state_out), 64'd0);
    chk("rst_free_valid", 64'(frl_free_valid_out), 64'd0);
    chk("rst_proto_err", 64'(proto_err_out), 64'd0);

    // flush_done outside FLUSH
    flush_done_in = 1'b1;
    cyc();
    flush_done_in = 1'b0;
    chk("stray_done_err", 64'(proto_err_out), 64'd1);
    chk("stray_done_state", 64'(state_out), 64'd0);

    repeat (3) cyc();
    chk("alloc_queue_empty", 64'(aq.size()), 64'd0);
    chk("free_queue_empty", 64'(fq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
